// File: rtl/irq_gateway.sv
// Interrupt gateway: turns raw level/edge interrupt lines into single outstanding
// PLIC requests with claim/complete flow control and saturating edge queues.
module irq_gateway #(
   parameter int NumSources = 30,
   parameter int MaxPending = 3,
   parameter int IdWidth    = $clog2(NumSources + 1)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [NumSources-1:0] irq_i,
   input  logic [NumSources-1:0] edge_i,
   input  logic                  claim_valid_i,
   input  logic [IdWidth-1:0]    claim_id_i,
   input  logic                  complete_valid_i,
   input  logic [IdWidth-1:0]    complete_id_i,
   input  logic                  clear_overflow_i,
   output logic [NumSources-1:0] irq_sources_o,
   output logic [NumSources-1:0] overflow_o
);

   localparam int CntWidth = $clog2(MaxPending + 1);
   localparam logic [CntWidth-1:0] CntMax = CntWidth'(MaxPending);
   localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);

   typedef enum logic [1:0] {
      IDLE,
      PENDING,
      ACTIVE
   } state_e;

   logic [NumSources-1:0] prev_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         prev_q <= '0;
      end else begin
         prev_q <= irq_i;
      end
   end

   for (genvar g = 0; g < NumSources; g++) begin : gen_src
      localparam logic [IdWidth-1:0] SrcId = IdWidth'(g + 1);

      state_e              state_q, state_d;
      logic [CntWidth-1:0] cnt_q, cnt_d;
      logic                ovf_q, ovf_d;
      logic                edgeSeen;
      logic                claimHit;
      logic                completeHit;
      logic                reqOut;

      assign edgeSeen    = irq_i[g] & ~prev_q[g];
      assign claimHit    = claim_valid_i && (claim_id_i == SrcId);
      assign completeHit = complete_valid_i && (complete_id_i == SrcId);

      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
         end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
         end
      end

      always_comb begin
         state_d = state_q;
         unique case (state_q)
            IDLE: begin
               if (edge_i[g] ? (edgeSeen || (cnt_q != '0)) : irq_i[g]) begin
                  state_d = PENDING;
               end
            end
            PENDING: begin
               if (claimHit) begin
                  state_d = ACTIVE;
               end
            end
            ACTIVE: begin
               if (completeHit) begin
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end

      // Leaving IDLE consumes one edge: a fresh edge in that cycle replaces the
      // queued one it would otherwise have taken, so the count only drops without one.
      always_comb begin
         cnt_d = cnt_q;
         ovf_d = ovf_q & ~clear_overflow_i;
         if (edge_i[g]) begin
            if (state_q == IDLE) begin
               if (!edgeSeen && (cnt_q != '0)) begin
                  cnt_d = cnt_q - CntOne;
               end
            end else if (edgeSeen) begin
               if (cnt_q == CntMax) begin
                  ovf_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + CntOne;
               end
            end
         end
      end

      always_comb begin
         reqOut = (state_q == PENDING);
      end

      assign irq_sources_o[g] = reqOut;
      assign overflow_o[g]    = ovf_q;
   end

endmodule

// File: tb/tb_irq_gateway.sv
// Testbench for irq_gateway: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a queue-count behavioural model.
module tb_irq_gateway;

   localparam int NS = 30;
   localparam int MP = 3;
   localparam int IW = 5;

   localparam int S_IDLE   = 0;
   localparam int S_WAIT   = 1;
   localparam int S_SERVED = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [NS-1:0] irq = '0;
   logic [NS-1:0] edg = '0;
   logic          cv  = 1'b0;
   logic [IW-1:0] cid = '0;
   logic          pv  = 1'b0;
   logic [IW-1:0] pid = '0;
   logic          clr = 1'b0;
   logic [NS-1:0] irqSources;
   logic [NS-1:0] overflow;

   int vectors     = 0;
   int miscompares = 0;
   bit compareEn   = 1'b0;
   int reqCount;

   int            mSt   [NS];
   int            mQ    [NS];
   bit            mOvf  [NS];
   bit            mPrev [NS];
   logic [NS-1:0] expReq = '0;
   logic [NS-1:0] expOvf = '0;

   irq_gateway #(
      .NumSources(NS),
      .MaxPending(MP)
   ) dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .irq_i           (irq),
      .edge_i          (edg),
      .claim_valid_i   (cv),
      .claim_id_i      (cid),
      .complete_valid_i(pv),
      .complete_id_i   (pid),
      .clear_overflow_i(clr),
      .irq_sources_o   (irqSources),
      .overflow_o      (overflow)
   );

   always #5 clk = ~clk;

   // Reference model: each source is waiting/served/idle plus a count of banked edges.
   always @(posedge clk) begin
      int  nst;
      int  avail;
      bit  e;
      bit  newOvf;
      if (rst) begin
         for (int i = 0; i < NS; i++) begin
            mSt[i] = S_IDLE; mQ[i] = 0; mOvf[i] = 1'b0; mPrev[i] = 1'b0;
         end
      end else begin
         for (int i = 0; i < NS; i++) begin
            e = irq[i] && !mPrev[i];
            nst = mSt[i];
            if (mSt[i] == S_WAIT && cv && int'(cid) == i + 1) nst = S_SERVED;
            if (mSt[i] == S_SERVED && pv && int'(pid) == i + 1) nst = S_IDLE;
            newOvf = mOvf[i] && !clr;
            if (edg[i]) begin
               avail = mQ[i] + (e ? 1 : 0);
               if (mSt[i] == S_IDLE && avail > 0) begin
                  nst = S_WAIT;
                  avail = avail - 1;
               end
               if (avail > MP) begin
                  avail = MP;
                  newOvf = 1'b1;
               end
               mQ[i] = avail;
            end else if (mSt[i] == S_IDLE && irq[i]) begin
               nst = S_WAIT;
            end
            mSt[i] = nst;
            mOvf[i] = newOvf;
            mPrev[i] = irq[i];
         end
      end
      for (int i = 0; i < NS; i++) begin
         expReq[i] = (mSt[i] == S_WAIT);
         expOvf[i] = mOvf[i];
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // Pulse inputs are held for exactly one rising edge; returns on the following falling edge.
   task automatic applyStimulus(input logic claimV, input int claimId, input logic compV,
                                input int compId, input logic clrV);
      cv  = claimV;
      cid = IW'(claimId);
      pv  = compV;
      pid = IW'(compId);
      clr = clrV;
      @(negedge clk);
      cv  = 1'b0;
      pv  = 1'b0;
      clr = 1'b0;
   endtask

   task automatic idleCycle();
      applyStimulus(1'b0, 0, 1'b0, 0, 1'b0);
   endtask

   always @(negedge clk) begin
      if (compareEn) begin
         checkOutput("model_irq_sources", {2'b00, irqSources}, {2'b00, expReq});
         checkOutput("model_overflow", {2'b00, overflow}, {2'b00, expOvf});
      end
   end

   initial begin
      @(negedge clk);
      @(negedge clk);
      compareEn = 1'b1;
      checkOutput("reset_req", {2'b00, irqSources}, 32'h0);
      checkOutput("reset_ovf", {2'b00, overflow}, 32'h0);
      rst = 1'b0;

      $display("[TB] level source 0");
      irq[0] = 1'b1;
      idleCycle();
      checkOutput("lvl_request", irqSources[0], 1);
      applyStimulus(1'b1, 1, 1'b0, 0, 1'b0);
      checkOutput("lvl_claim_drop", irqSources[0], 0);
      applyStimulus(1'b0, 0, 1'b1, 1, 1'b0);
      checkOutput("lvl_complete_gap", irqSources[0], 0);
      idleCycle();
      checkOutput("lvl_rerequest", irqSources[0], 1);
      irq[0] = 1'b0;
      applyStimulus(1'b1, 1, 1'b0, 0, 1'b0);
      applyStimulus(1'b0, 0, 1'b1, 1, 1'b0);
      idleCycle();
      idleCycle();
      checkOutput("lvl_quiet", irqSources[0], 0);

      $display("[TB] edge source 3 queue and overflow");
      edg[3] = 1'b1;
      irq[3] = 1'b1;
      idleCycle();
      checkOutput("edge_first_req", irqSources[3], 1);
      irq[3] = 1'b0;
      applyStimulus(1'b1, 4, 1'b0, 0, 1'b0);
      repeat (5) begin
         irq[3] = 1'b1;
         idleCycle();
         irq[3] = 1'b0;
         idleCycle();
      end
      checkOutput("edge_overflow_set", overflow[3], 1);
      checkOutput("edge_active_low", irqSources[3], 0);
      reqCount = 0;
      repeat (5) begin
         applyStimulus(1'b0, 0, 1'b1, 4, 1'b0);
         idleCycle();
         if (irqSources[3]) reqCount++;
         applyStimulus(1'b1, 4, 1'b0, 0, 1'b0);
      end
      checkOutput("edge_queue_drain", reqCount, 3);
      checkOutput("edge_overflow_sticky", overflow[3], 1);
      applyStimulus(1'b0, 0, 1'b0, 0, 1'b1);
      checkOutput("edge_overflow_clear", overflow[3], 0);

      $display("[TB] ignored claims and completes");
      irq[0] = 1'b1;
      idleCycle();
      checkOutput("ign_setup", {2'b00, irqSources}, 32'h1);
      applyStimulus(1'b1, 0, 1'b0, 0, 1'b0);
      checkOutput("ign_claim_id0", {2'b00, irqSources}, 32'h1);
      applyStimulus(1'b1, NS + 1, 1'b0, 0, 1'b0);
      checkOutput("ign_claim_oor", {2'b00, irqSources}, 32'h1);
      applyStimulus(1'b0, 0, 1'b1, 6, 1'b0);
      checkOutput("ign_complete_idle", {2'b00, irqSources}, 32'h1);
      applyStimulus(1'b0, 0, 1'b1, 1, 1'b0);
      checkOutput("ign_complete_pending", {2'b00, irqSources}, 32'h1);
      applyStimulus(1'b1, 1, 1'b0, 0, 1'b0);
      irq[0] = 1'b0;
      applyStimulus(1'b0, 0, 1'b1, 1, 1'b0);

      $display("[TB] same-cycle claim and complete");
      irq[1] = 1'b1;
      irq[4] = 1'b1;
      idleCycle();
      checkOutput("same_setup", {2'b00, irqSources}, 32'h12);
      applyStimulus(1'b1, 5, 1'b0, 0, 1'b0);
      irq[4] = 1'b0;
      applyStimulus(1'b1, 2, 1'b1, 5, 1'b0);
      checkOutput("same_both_low", {2'b00, irqSources}, 32'h0);
      irq[4] = 1'b1;
      idleCycle();
      checkOutput("same_cmp_applied", irqSources[4], 1);
      checkOutput("same_claim_applied", irqSources[1], 0);
      applyStimulus(1'b0, 0, 1'b1, 2, 1'b0);
      idleCycle();
      checkOutput("same_src1_repend", irqSources[1], 1);
      applyStimulus(1'b1, 2, 1'b1, 2, 1'b0);
      checkOutput("same_id_claimed", irqSources[1], 0);
      idleCycle();
      checkOutput("same_id_stays_active", irqSources[1], 0);
      irq[1] = 1'b0;
      irq[4] = 1'b0;
      applyStimulus(1'b1, 5, 1'b1, 2, 1'b0);
      applyStimulus(1'b0, 0, 1'b1, 5, 1'b0);
      idleCycle();

      $display("[TB] edge coinciding with consumption");
      edg[7] = 1'b1;
      irq[7] = 1'b1;
      idleCycle();
      irq[7] = 1'b0;
      applyStimulus(1'b1, 8, 1'b0, 0, 1'b0);
      irq[7] = 1'b1;
      idleCycle();
      irq[7] = 1'b0;
      applyStimulus(1'b0, 0, 1'b1, 8, 1'b0);
      irq[7] = 1'b1;
      idleCycle();
      checkOutput("coinc_request", irqSources[7], 1);
      irq[7] = 1'b0;
      applyStimulus(1'b1, 8, 1'b0, 0, 1'b0);
      applyStimulus(1'b0, 0, 1'b1, 8, 1'b0);
      idleCycle();
      checkOutput("coinc_queued_one", irqSources[7], 1);
      applyStimulus(1'b1, 8, 1'b0, 0, 1'b0);
      applyStimulus(1'b0, 0, 1'b1, 8, 1'b0);
      idleCycle();
      checkOutput("coinc_queue_empty", irqSources[7], 0);

      $display("[TB] reset mid-operation");
      edg[9]  = 1'b1;
      edg[10] = 1'b1;
      edg[11] = 1'b1;
      irq[9]  = 1'b1;
      irq[10] = 1'b1;
      irq[0]  = 1'b1;
      idleCycle();
      irq[10] = 1'b0;
      applyStimulus(1'b1, 11, 1'b0, 0, 1'b0);
      repeat (2) begin
         irq[10] = 1'b1;
         idleCycle();
         irq[10] = 1'b0;
         idleCycle();
      end
      irq[11] = 1'b1;
      idleCycle();
      rst = 1'b1;
      idleCycle();
      checkOutput("rst_req_clear", {2'b00, irqSources}, 32'h0);
      checkOutput("rst_ovf_clear", {2'b00, overflow}, 32'h0);
      rst = 1'b0;
      idleCycle();
      checkOutput("rst_held_edge_req", irqSources[11], 1);
      checkOutput("rst_queue_discarded", irqSources[10], 0);
      applyStimulus(1'b1, 12, 1'b0, 0, 1'b0);
      applyStimulus(1'b0, 0, 1'b1, 12, 1'b0);
      idleCycle();
      idleCycle();
      checkOutput("rst_single_request", irqSources[11], 0);

      $display("[TB] randomized run");
      irq = '0;
      edg = '0;
      rst = 1'b1;
      idleCycle();
      rst = 1'b0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         for (int i = 0; i < NS; i++) begin
            if ($urandom_range(0, 7) == 0) irq[i] = ~irq[i];
         end
         if (cyc % 64 == 0) edg = NS'($urandom());
         rst = ($urandom_range(0, 499) == 0);
         applyStimulus(1'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
                       1'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
                       ($urandom_range(0, 31) == 0));
      end
      rst = 1'b0;
      idleCycle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
